// File: rtl/mem_ctrl_if.sv
// Pipeline-side and RAM-side signal bundle of the byte-serial memory controller.
// The slave modport is the controller's view; master is the surrounding system.
interface mem_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned RAM_AW = 17
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_data;
    logic              if_done;

    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_size;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_done;

    logic [7:0]        ram_din;
    logic [7:0]        ram_dout;
    logic [RAM_AW-1:0] ram_a;
    logic              ram_wr;

    logic              stallreq_if;
    logic              stallreq_mem;

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_size, mem_addr, mem_wdata, ram_din,
        output if_data, if_done, mem_rdata, mem_done, ram_dout, ram_a, ram_wr,
               stallreq_if, stallreq_mem
    );

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_size, mem_addr, mem_wdata, ram_din,
        input  if_data, if_done, mem_rdata, mem_done, ram_dout, ram_a, ram_wr,
               stallreq_if, stallreq_mem
    );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial controller between pipeline fetch/load/store ports and an 8-bit
// synchronous RAM; words are assembled and split little-endian.
module mem_ctrl #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned RAM_AW = 17
) (
    input  logic       clk,
    input  logic       rst,
    mem_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        last_q, last_d;
    logic              is_mem_q, is_mem_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       buffer_q, buffer_d;
    logic [RAM_AW-1:0] ram_a_q, ram_a_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              ram_wr_q, ram_wr_d;
    logic              if_done_q, if_done_d;
    logic              mem_done_q, mem_done_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;

    logic              can_accept;
    logic              accept_mem;
    logic              accept_if;
    logic [1:0]        rd_idx;
    logic [1:0]        wr_idx;

    // A done cycle blocks acceptance so a still-high request cannot retrigger.
    assign can_accept = (state_q == IDLE) & ~if_done_q & ~mem_done_q;
    assign accept_mem = can_accept & bus.mem_req;
    assign accept_if  = can_accept & ~bus.mem_req & bus.if_req;
    assign rd_idx     = 2'(cnt_q - 3'd1);
    assign wr_idx     = 2'(cnt_q + 3'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_mem) begin
                    state_d = bus.mem_we ? WRITE : READ;
                end else if (accept_if) begin
                    state_d = READ;
                end
            end
            READ: begin
                if (cnt_q == last_q + 3'd1) begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (cnt_q == last_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values; cnt counts edges since the accept edge.
    always_comb begin
        cnt_d       = cnt_q;
        last_d      = last_q;
        is_mem_d    = is_mem_q;
        wdata_d     = wdata_q;
        buffer_d    = buffer_q;
        ram_a_d     = ram_a_q;
        ram_dout_d  = ram_dout_q;
        ram_wr_d    = ram_wr_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_mem) begin
                    is_mem_d = 1'b1;
                    last_d   = (bus.mem_size == 2'd2) ? 3'd3 : {1'b0, bus.mem_size};
                    wdata_d  = bus.mem_wdata;
                    ram_a_d  = bus.mem_addr[RAM_AW-1:0];
                    cnt_d    = 3'd0;
                    buffer_d = 32'd0;
                    ram_wr_d = bus.mem_we;
                    if (bus.mem_we) begin
                        ram_dout_d = bus.mem_wdata[7:0];
                    end
                end else if (accept_if) begin
                    is_mem_d = 1'b0;
                    last_d   = 3'd3;
                    ram_a_d  = bus.if_addr[RAM_AW-1:0];
                    cnt_d    = 3'd0;
                    buffer_d = 32'd0;
                    ram_wr_d = 1'b0;
                end
            end
            READ: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q < last_q) begin
                    ram_a_d = ram_a_q + RAM_AW'(1);
                end
                // Byte k arrives one cycle after its address, captured at E(k+2).
                if (cnt_q != 3'd0) begin
                    buffer_d[{rd_idx, 3'b000} +: 8] = bus.ram_din;
                end
                if (cnt_q == last_q + 3'd1) begin
                    if (is_mem_q) begin
                        mem_rdata_d = buffer_d;
                        mem_done_d  = 1'b1;
                    end else begin
                        if_data_d = buffer_d;
                        if_done_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q < last_q) begin
                    ram_a_d    = ram_a_q + RAM_AW'(1);
                    ram_dout_d = wdata_q[{wr_idx, 3'b000} +: 8];
                    ram_wr_d   = 1'b1;
                end else begin
                    ram_wr_d   = 1'b0;
                    mem_done_d = 1'b1;
                end
            end
            default: begin
                ram_wr_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= 3'd0;
            last_q      <= 3'd0;
            is_mem_q    <= 1'b0;
            wdata_q     <= 32'd0;
            buffer_q    <= 32'd0;
            ram_a_q     <= '0;
            ram_dout_q  <= 8'd0;
            ram_wr_q    <= 1'b0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_data_q   <= 32'd0;
            mem_rdata_q <= 32'd0;
        end else begin
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            is_mem_q    <= is_mem_d;
            wdata_q     <= wdata_d;
            buffer_q    <= buffer_d;
            ram_a_q     <= ram_a_d;
            ram_dout_q  <= ram_dout_d;
            ram_wr_q    <= ram_wr_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign bus.ram_a        = ram_a_q;
    assign bus.ram_dout     = ram_dout_q;
    assign bus.ram_wr       = ram_wr_q;
    assign bus.if_done      = if_done_q;
    assign bus.mem_done     = mem_done_q;
    assign bus.if_data      = if_data_q;
    assign bus.mem_rdata    = mem_rdata_q;
    assign bus.stallreq_if  = bus.if_req & ~if_done_q;
    assign bus.stallreq_mem = bus.mem_req & ~mem_done_q;

    // Address bits above the RAM range are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.if_addr[ADDR_W-1:RAM_AW], bus.mem_addr[ADDR_W-1:RAM_AW]};

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte RAM model, fetch/load/store latency and data,
// arbitration, address wrap and mid-store reset.
module tb_mem_ctrl;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned RAM_AW = 17;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_ctrl_if #(.ADDR_W(ADDR_W), .RAM_AW(RAM_AW)) bus ();

    mem_ctrl #(.ADDR_W(ADDR_W), .RAM_AW(RAM_AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [7:0]        ram [0:(1<<RAM_AW)-1];
    logic              pl_en = 1'b0;
    logic [RAM_AW-1:0] pl_a  = '0;
    logic [7:0]        pl_d  = 8'd0;

    // Synchronous-read byte RAM; pl_* preloads contents while the controller is idle.
    always @(posedge clk) begin
        if (pl_en) begin
            ram[pl_a] <= pl_d;
        end else if (bus.ram_wr) begin
            ram[bus.ram_a] <= bus.ram_dout;
        end
        bus.ram_din <= ram[bus.ram_a];
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [RAM_AW-1:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_a  = a;
        pl_d  = d;
        pl_en = 1'b1;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic do_mem(input logic we, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat,
                          output logic [31:0] rdata, output int wrc);
        bus.mem_we    = we;
        bus.mem_size  = size;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.mem_req   = 1'b1;
        lat   = 99;
        wrc   = 0;
        rdata = 32'd0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            wrc += int'(bus.ram_wr);
            if (bus.mem_done) begin
                lat   = i - 1;
                rdata = bus.mem_rdata;
                check("stallreq_mem_in_done", 32'(bus.stallreq_mem), 32'd0);
                break;
            end
        end
        bus.mem_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_if(input logic [31:0] addr, output int lat, output logic [31:0] data);
        bus.if_addr = addr;
        bus.if_req  = 1'b1;
        lat  = 99;
        data = 32'd0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) check("stallreq_if_busy", 32'(bus.stallreq_if), 32'd1);
            if (bus.if_done) begin
                lat  = i - 1;
                data = bus.if_data;
                check("stallreq_if_in_done", 32'(bus.stallreq_if), 32'd0);
                break;
            end
        end
        bus.if_req = 1'b0;
        @(negedge clk);
    endtask

    // Both requests already raised by the caller; records which done came first.
    task automatic race(output int first, output logic [31:0] md, output logic [31:0] ifd);
        bit got_m = 1'b0;
        bit got_i = 1'b0;
        first = 0;
        md    = 32'd0;
        ifd   = 32'd0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.mem_done && !got_m) begin
                got_m = 1'b1;
                md = bus.mem_rdata;
                bus.mem_req = 1'b0;
                if (first == 0) first = 1;
            end
            if (bus.if_done && !got_i) begin
                got_i = 1'b1;
                ifd = bus.if_data;
                bus.if_req = 1'b0;
                if (first == 0) first = 2;
            end
            if (got_m && got_i) break;
        end
        bus.mem_req = 1'b0;
        bus.if_req  = 1'b0;
        @(negedge clk);
    endtask

    int          lat;
    int          wrc;
    int          first;
    logic [31:0] rd;
    logic [31:0] rd2;

    initial begin
        bus.if_req    = 1'b0;
        bus.if_addr   = 32'd0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_size  = 2'd0;
        bus.mem_addr  = 32'd0;
        bus.mem_wdata = 32'd0;

        repeat (2) @(negedge clk);
        check("rst_ram_a", 32'(bus.ram_a), 32'd0);
        check("rst_ram_wr", 32'(bus.ram_wr), 32'd0);
        check("rst_ram_dout", 32'(bus.ram_dout), 32'd0);
        check("rst_dones", {30'd0, bus.if_done, bus.mem_done}, 32'd0);
        check("rst_if_data", bus.if_data, 32'd0);
        check("rst_mem_rdata", bus.mem_rdata, 32'd0);
        rst = 1'b1;

        poke(17'h100, 8'h13);
        poke(17'h101, 8'h05);
        poke(17'h102, 8'hA0);
        poke(17'h103, 8'h00);
        do_if(32'h100, lat, rd);
        check("fetch_lat", 32'(lat), 32'd5);
        check("fetch_data", rd, 32'h00A00513);
        check("fetch_hold", bus.if_data, 32'h00A00513);

        do_mem(1'b1, 2'd3, 32'h20, 32'hDEADBEEF, lat, rd, wrc);
        check("stw_lat", 32'(lat), 32'd4);
        check("stw_wr_cycles", 32'(wrc), 32'd4);
        check("stw_ram", {ram[32'h23], ram[32'h22], ram[32'h21], ram[32'h20]}, 32'hDEADBEEF);
        do_mem(1'b0, 2'd3, 32'h20, 32'd0, lat, rd, wrc);
        check("ldw_lat", 32'(lat), 32'd5);
        check("ldw_data", rd, 32'hDEADBEEF);

        do_mem(1'b0, 2'd0, 32'h21, 32'd0, lat, rd, wrc);
        check("ldb_lat", 32'(lat), 32'd2);
        check("ldb_data", rd, 32'h000000BE);
        check("ldb_hold", bus.mem_rdata, 32'h000000BE);

        do_mem(1'b0, 2'd2, 32'h20, 32'd0, lat, rd, wrc);
        check("ld_size2_data", rd, 32'hDEADBEEF);

        poke(17'h31, 8'h77);
        do_mem(1'b1, 2'd0, 32'h30, 32'hFFFFFF5A, lat, rd, wrc);
        check("stb_lat", 32'(lat), 32'd1);
        check("stb_ram", {16'd0, ram[32'h31], ram[32'h30]}, 32'h0000775A);

        // Simultaneous requests: load served before fetch.
        bus.mem_we   = 1'b0;
        bus.mem_size = 2'd3;
        bus.mem_addr = 32'h20;
        bus.mem_req  = 1'b1;
        bus.if_addr  = 32'h100;
        bus.if_req   = 1'b1;
        race(first, rd, rd2);
        check("prio_first", 32'(first), 32'd1);
        check("prio_mem_data", rd, 32'hDEADBEEF);
        check("prio_if_data", rd2, 32'h00A00513);

        // Fetch in flight is not preempted by a later load.
        bus.if_addr = 32'h100;
        bus.if_req  = 1'b1;
        @(negedge clk);
        bus.mem_we   = 1'b0;
        bus.mem_size = 2'd0;
        bus.mem_addr = 32'h100;
        bus.mem_req  = 1'b1;
        race(first, rd, rd2);
        check("nopreempt_first", 32'(first), 32'd2);
        check("nopreempt_mem_data", rd, 32'h00000013);

        poke(17'h1FFFF, 8'h34);
        poke(17'h00000, 8'h12);
        do_mem(1'b0, 2'd1, 32'hFFFFFFFF, 32'd0, lat, rd, wrc);
        check("wrap_lat", 32'(lat), 32'd3);
        check("wrap_data", rd, 32'h00001234);

        // Reset after two bytes of a word store have been written.
        for (int a = 0; a < 4; a++) poke(17'(32'h40 + a), 8'hAA);
        bus.mem_we    = 1'b1;
        bus.mem_size  = 2'd3;
        bus.mem_addr  = 32'h40;
        bus.mem_wdata = 32'h11223344;
        bus.mem_req   = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bus.mem_req = 1'b0;
        #1;
        check("rstmid_ram_wr", 32'(bus.ram_wr), 32'd0);
        check("rstmid_ram_a", 32'(bus.ram_a), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        wrc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            wrc += int'(bus.mem_done) + int'(bus.ram_wr);
        end
        check("rstmid_no_done", 32'(wrc), 32'd0);
        check("rstmid_ram", {ram[32'h43], ram[32'h42], ram[32'h41], ram[32'h40]}, 32'hAAAA3344);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
